// File: rtl/avmm_reg_bridge_m_if.sv
// 32-bit Avalon-MM slave-side bundle carried between the width translator
// and the register bridge.
interface avmm_if #(
   parameter int AW = 16
);
   logic [AW-1:0] address;
   logic          read;
   logic          write;
   logic [31:0]   writedata;
   logic [3:0]    byteenable;
   logic [3:0]    burstcount;
   logic          waitrequest;
   logic [31:0]   readdata;
   logic          readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable, burstcount,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable, burstcount,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/avmm_reg_bridge_m.sv
// Avalon-MM to local req/ack register bus bridge with ack-timeout watchdog.
// Optional AVMM_REG_BRIDGE_ERR_CNT_EN adds a saturating timeout counter, also readable in-band.
module avmm_reg_bridge_m #(
   parameter int          AW        = 16,
   parameter int          TO_CYCLES = 64,
   parameter logic [31:0] TO_RDATA  = 32'hDEAD_BEEF
) (
   input  logic          clk,
   input  logic          rst,
   avmm_if.slave         s,
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-3:0] bus_addr,
   output logic [31:0]   bus_wdata,
   output logic [3:0]    bus_be,
   input  logic          bus_ack,
   input  logic [31:0]   bus_rdata,
`ifdef AVMM_REG_BRIDGE_ERR_CNT_EN
   output logic [15:0]   err_cnt,
`endif
   output logic          timeout
);

   localparam int CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE, RESP} state_e;

   state_e          state_q, state_d;
   logic [AW-3:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      be_q, be_d;
   logic            we_q, we_d;
   logic            int_q, int_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            int_hit;
   logic            ack_eff;
   logic [31:0]     rdata_eff;

   // Address LSBs and burstcount carry no information for single-beat word access.
   logic unused_ok;
   assign unused_ok = ^{s.burstcount, s.address[1:0]};

`ifdef AVMM_REG_BRIDGE_ERR_CNT_EN
   logic [15:0] err_q;

   assign int_hit   = s.read & ~s.write & (&s.address[AW-1:2]);
   assign rdata_eff = int_q ? {16'h0, err_q} : bus_rdata;
   assign err_cnt   = err_q;

   always_ff @(posedge clk) begin
      if (rst)                              err_q <= '0;
      else if (timeout && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
   end
`else
   assign int_hit   = 1'b0;
   assign rdata_eff = bus_rdata;
`endif

   // Internal register reads complete on the first REQ cycle, ignoring the bus.
   assign ack_eff = int_q | bus_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         int_q   <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         we_q    <= we_d;
         int_q   <= int_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      we_d    = we_q;
      int_d   = int_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      bus_req = 1'b0;
      timeout = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (s.read | s.write) begin
               addr_d  = s.address[AW-1:2];
               wdata_d = s.writedata;
               be_d    = s.byteenable;
               we_d    = s.write;
               int_d   = int_hit;
               state_d = REQ;
            end
         end
         REQ: begin
            bus_req = ~int_q;
            cnt_d   = cnt_q + 1'b1;
            // Read register only moves for reads so readdata holds outside RESP.
            if (ack_eff) begin
               if (!we_q) rdata_d = rdata_eff;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               if (!we_q) rdata_d = TO_RDATA;
               timeout = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = we_q ? IDLE : RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus_we          = bus_req & we_q;
   assign bus_addr        = addr_q;
   assign bus_wdata       = wdata_q;
   assign bus_be          = be_q;
   assign s.waitrequest   = (state_q != DONE);
   assign s.readdatavalid = (state_q == RESP);
   assign s.readdata      = rdata_q;

endmodule

// File: tb/tb_avmm_reg_bridge_m.sv
// Directed bench for avmm_reg_bridge_m: write, delayed-ack read, timeout,
// ack-on-last-cycle, back-to-back reads, reset mid-transaction.
module tb_avmm_reg_bridge_m;
   logic        clk = 1'b0;
   logic        rst;
   logic        bus_req, bus_we, bus_ack, timeout;
   logic [13:0] bus_addr;
   logic [31:0] bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
`ifdef AVMM_REG_BRIDGE_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int rv_cyc[$];
   logic [31:0] rv_dat[$];

   avmm_if #(.AW(16)) s_if ();

   avmm_reg_bridge_m #(.AW(16), .TO_CYCLES(64), .TO_RDATA(32'hDEAD_BEEF)) dut (
      .clk       (clk),
      .rst       (rst),
      .s         (s_if),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_be    (bus_be),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
`ifdef AVMM_REG_BRIDGE_ERR_CNT_EN
      .err_cnt   (err_cnt),
`endif
      .timeout   (timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (!rst && s_if.readdatavalid) begin
         rv_cyc.push_back(cyc);
         rv_dat.push_back(s_if.readdata);
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int to_cnt;
      int reqs;
      logic [31:0] dat [3];
      dat[0] = 32'h1111_0001; dat[1] = 32'h2222_0002; dat[2] = 32'h3333_0003;

      rst = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
      s_if.address = '0; s_if.read = 1'b0; s_if.write = 1'b0;
      s_if.writedata = '0; s_if.byteenable = '0; s_if.burstcount = 4'd1;
      repeat (3) tick();

      // reset values
      chk("rst_wait",   32'(s_if.waitrequest),   32'd1);
      chk("rst_rvalid", 32'(s_if.readdatavalid), 32'd0);
      chk("rst_rdata",  s_if.readdata,           32'd0);
      chk("rst_req",    32'(bus_req),            32'd0);
      chk("rst_we",     32'(bus_we),             32'd0);
      chk("rst_addr",   32'(bus_addr),           32'd0);
      chk("rst_wdata",  bus_wdata,               32'd0);
      chk("rst_be",     32'(bus_be),             32'd0);
      chk("rst_to",     32'(timeout),            32'd0);
      rst = 1'b0;
      tick();

      // single write, ack in first REQ cycle
      s_if.address = 16'h0010; s_if.writedata = 32'h1234_5678;
      s_if.byteenable = 4'hF; s_if.write = 1'b1;
      chk("wr_c0_wait", 32'(s_if.waitrequest), 32'd1);
      tick();
      chk("wr_c1_req",   32'(bus_req),   32'd1);
      chk("wr_c1_we",    32'(bus_we),    32'd1);
      chk("wr_c1_addr",  32'(bus_addr),  32'h0004);
      chk("wr_c1_wdata", bus_wdata,      32'h1234_5678);
      chk("wr_c1_be",    32'(bus_be),    32'hF);
      chk("wr_c1_wait",  32'(s_if.waitrequest), 32'd1);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      chk("wr_c2_wait", 32'(s_if.waitrequest), 32'd0);
      chk("wr_c2_req",  32'(bus_req),  32'd0);
      chk("wr_c2_we",   32'(bus_we),   32'd0);
      s_if.write = 1'b0;
      tick();
      chk("wr_c3_wait",   32'(s_if.waitrequest),   32'd1);
      chk("wr_c3_rvalid", 32'(s_if.readdatavalid), 32'd0);

      // read, ack on 5th REQ cycle
      s_if.address = 16'h0008; s_if.read = 1'b1;
      tick();
      reqs = 0;
      for (int i = 0; i < 5; i++) begin
         reqs += int'(bus_req);
         chk("rd5_wait", 32'(s_if.waitrequest), 32'd1);
         if (i == 4) begin bus_ack = 1'b1; bus_rdata = 32'hCAFE_0001; end
         tick();
      end
      bus_ack = 1'b0; bus_rdata = '0;
      chk("rd5_reqs",   32'(reqs),                 32'd5);
      chk("rd5_addr",   32'(bus_addr),             32'h0002);
      chk("rd5_wait",   32'(s_if.waitrequest),     32'd0);
      chk("rd5_req_dn", 32'(bus_req),              32'd0);
      chk("rd5_rv_dn",  32'(s_if.readdatavalid),   32'd0);
      s_if.read = 1'b0;
      tick();
      chk("rd5_rvalid", 32'(s_if.readdatavalid),   32'd1);
      chk("rd5_rdata",  s_if.readdata,             32'hCAFE_0001);
      tick();
      chk("rd5_rv_off", 32'(s_if.readdatavalid),   32'd0);
      chk("rd5_hold",   s_if.readdata,             32'hCAFE_0001);

      // read with no ack: timeout after 64 REQ cycles
      s_if.address = 16'h000C; s_if.read = 1'b1;
      tick();
      reqs = 0; to_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         reqs   += int'(bus_req);
         to_cnt += int'(timeout);
         if (i == 63) chk("to_pulse_last", 32'(timeout), 32'd1);
         tick();
      end
      chk("to_reqs",   32'(reqs),   32'd64);
      chk("to_pulses", 32'(to_cnt), 32'd1);
      chk("to_dn_req", 32'(bus_req), 32'd0);
      chk("to_dn_to",  32'(timeout), 32'd0);
      chk("to_dn_wait", 32'(s_if.waitrequest), 32'd0);
      s_if.read = 1'b0;
      tick();
      chk("to_rvalid", 32'(s_if.readdatavalid), 32'd1);
      chk("to_rdata",  s_if.readdata,           32'hDEAD_BEEF);
`ifdef AVMM_REG_BRIDGE_ERR_CNT_EN
      chk("to_errcnt", 32'(err_cnt), 32'd1);
`endif
      tick();

      // ack coincides with final count: no timeout
      s_if.address = 16'h0014; s_if.read = 1'b1; bus_rdata = 32'h5A5A_0004;
      tick();
      to_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         if (i == 63) bus_ack = 1'b1;
         #1;
         to_cnt += int'(timeout);
         tick();
      end
      bus_ack = 1'b0;
      chk("ackl_pulses", 32'(to_cnt), 32'd0);
      chk("ackl_wait",   32'(s_if.waitrequest), 32'd0);
      s_if.read = 1'b0;
      tick();
      chk("ackl_rvalid", 32'(s_if.readdatavalid), 32'd1);
      chk("ackl_rdata",  s_if.readdata,           32'h5A5A_0004);
      tick();

      // three back-to-back reads, next command presented during RESP
      rv_cyc.delete(); rv_dat.delete();
      s_if.address = 16'h0100; s_if.read = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         chk("b2b_req",  32'(bus_req),  32'd1);
         chk("b2b_addr", 32'(bus_addr), 32'h0040 + 32'(n));
         bus_ack = 1'b1; bus_rdata = dat[n];
         tick();
         bus_ack = 1'b0; bus_rdata = '0;
         tick();
         chk("b2b_resp_req", 32'(bus_req), 32'd0);
         if (n < 2) s_if.address = 16'h0100 + 16'(4 * (n + 1));
         else       s_if.read = 1'b0;
         tick();
      end
      repeat (2) tick();
      chk("b2b_count", 32'(rv_cyc.size()), 32'd3);
      if (rv_cyc.size() == 3) begin
         for (int n = 0; n < 3; n++) chk("b2b_data", rv_dat[n], dat[n]);
         chk("b2b_gap01", 32'(rv_cyc[1] - rv_cyc[0]), 32'd4);
         chk("b2b_gap12", 32'(rv_cyc[2] - rv_cyc[1]), 32'd4);
      end

      // all-ones word address
      s_if.address = 16'hFFFC; s_if.read = 1'b1; bus_rdata = 32'h7777_7777;
      tick();
`ifdef AVMM_REG_BRIDGE_ERR_CNT_EN
      chk("ones_req", 32'(bus_req), 32'd0);
`else
      chk("ones_req", 32'(bus_req), 32'd1);
      bus_ack = 1'b1;
`endif
      tick();
      bus_ack = 1'b0;
      chk("ones_wait", 32'(s_if.waitrequest), 32'd0);
      s_if.read = 1'b0;
      tick();
      chk("ones_rvalid", 32'(s_if.readdatavalid), 32'd1);
`ifdef AVMM_REG_BRIDGE_ERR_CNT_EN
      chk("ones_rdata", s_if.readdata, 32'h0000_0001);
`else
      chk("ones_rdata", s_if.readdata, 32'h7777_7777);
`endif
      bus_rdata = '0;
      tick();

      // reset while a read is in REQ
      rv_cyc.delete(); rv_dat.delete();
      s_if.address = 16'h0020; s_if.read = 1'b1;
      tick();
      chk("rstm_req_pre", 32'(bus_req), 32'd1);
      rst = 1'b1; s_if.read = 1'b0;
      tick();
      rst = 1'b0;
      chk("rstm_req",   32'(bus_req),            32'd0);
      chk("rstm_wait",  32'(s_if.waitrequest),   32'd1);
      chk("rstm_rdata", s_if.readdata,           32'd0);
      repeat (4) tick();
      chk("rstm_norv",  32'(rv_cyc.size()),      32'd0);
      s_if.address = 16'h0030; s_if.writedata = 32'h0BAD_F00D;
      s_if.byteenable = 4'h3; s_if.write = 1'b1;
      tick();
      chk("rstm_wr_req",  32'(bus_req),   32'd1);
      chk("rstm_wr_we",   32'(bus_we),    32'd1);
      chk("rstm_wr_addr", 32'(bus_addr),  32'h000C);
      chk("rstm_wr_data", bus_wdata,      32'h0BAD_F00D);
      chk("rstm_wr_be",   32'(bus_be),    32'h3);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      chk("rstm_wr_wait", 32'(s_if.waitrequest), 32'd0);
      s_if.write = 1'b0;
      tick();
      chk("rstm_wr_rv",   32'(rv_cyc.size()),    32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/avmm_reg_bridge_m.md
Name: avmm_reg_bridge_m

Overview:
Terminates the 32-bit Avalon-MM stream produced by the 64→32 data-width translator and converts each single-beat transaction into one request/acknowledge cycle on a simple local register bus. Peripheral register blocks hang off this bus.
Provides Avalon waitrequest and readdatavalid generation and a bus-timeout watchdog, so an unresponsive peripheral never hangs the host.

Parameters:
AW, 16, Avalon byte-address width (matches upstream translator).
TO_CYCLES, 64, local-bus cycles allowed for ack before timeout (>=2).
TO_RDATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
s  avmm_if.slave  -  32-bit Avalon-MM slave: address[AW-1:0], read, write, writedata[31:0], byteenable[3:0], burstcount, waitrequest, readdata[31:0], readdatavalid.
bus_req  out  1  local request strobe, held until ack or timeout.
bus_we  out  1  1 = write, 0 = read.
bus_addr  out  AW-2  word address = s.address[AW-1:2].
bus_wdata  out  32  write data.
bus_be  out  4  byte enables.
bus_ack  in  1  peripheral acknowledge; single cycle.
bus_rdata  in  32  read data, valid when bus_ack=1.
timeout  out  1  one-cycle pulse when a transaction times out.

Behaviour:
- Reset values: s.waitrequest=1, s.readdatavalid=0, s.readdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, timeout=0. FSM goes to IDLE and the timeout counter clears.
- s.waitrequest is 1 in every state except DONE.
- FSM states: IDLE, REQ, DONE, RESP.
- IDLE:
  - On s.read|s.write, latch address, writedata, byteenable and op (write wins if both are set). Go to REQ.
  - burstcount is ignored; every command is treated as a single beat.
- REQ:
  - bus_req=1 with latched fields stable.
  - Counter increments each cycle.
  - On bus_ack: capture bus_rdata and go to DONE.
  - If the counter reaches TO_CYCLES-1 without ack: load TO_RDATA into the read register, pulse timeout=1, go to DONE.
  - If ack and the final count coincide, ack wins (no timeout).
- DONE:
  - bus_req=0, s.waitrequest=0 for exactly one cycle. The master's held command is accepted here and is not re-latched.
  - Writes go to IDLE. Reads go to RESP.
- RESP:
  - s.readdatavalid=1 with s.readdata=captured value for one cycle, then go to IDLE.
  - A command present during RESP is ignored this cycle and latched in IDLE next cycle.
- Latency (command at cycle 0, ack in first REQ cycle at cycle 1):
  - waitrequest low at cycle 2.
  - readdatavalid at cycle 3.
  - Back-to-back throughput: one write per 3 cycles, one read per 4 cycles.
- Exactly one outstanding transaction at any time; readdatavalid count always equals reads accepted.
- bus_ack outside REQ is ignored.
- Reset mid-transaction: all state aborts immediately. No readdatavalid is produced for the aborted read. bus_req drops in the cycle after reset is sampled.
- s.readdata holds its last value outside RESP.

Optional Feature:
Macro AVMM_REG_BRIDGE_ERR_CNT_EN.
- Defined: adds output err_cnt[15:0].
  - Increments on each timeout pulse and saturates at 16'hFFFF.
  - Cleared by rst.
  - Also readable in-band: a read of word address all-ones is answered internally with {16'h0, err_cnt} without issuing bus_req. Latency is identical (REQ lasts one cycle).
- Undefined: port and counter absent. The all-ones address is forwarded to the local bus like any other.

Test Plan:
- Write addr 16'h0010, data 32'h1234_5678, be 4'hF; ack in first REQ cycle -> bus_addr=14'h0004, bus_wdata=32'h1234_5678, bus_we=1 for 1 cycle; waitrequest low at cycle 2; no readdatavalid.
- Read addr 16'h0008; ack after 5 REQ cycles with bus_rdata=32'hCAFE_0001 -> bus_req high 5 cycles; waitrequest low 1 cycle; readdatavalid 1 cycle later with readdata=32'hCAFE_0001.
- Read with no ack, TO_CYCLES=64 -> bus_req high 64 cycles, timeout pulses once; readdata=32'hDEAD_BEEF with readdatavalid; with the macro defined, err_cnt=1.
- Ack on the final timeout cycle -> no timeout pulse; readdata=bus_rdata.
- 3 back-to-back reads with immediate ack -> exactly 3 readdatavalid pulses, in order, 4 cycles apart.
- Assert rst while in REQ of a read -> bus_req=0 next cycle; no readdatavalid; the next write completes normally.
